mor1kx_dbus_sram_responder: RTL and testbench

Responder end of the mor1kx CPU data bus (dbus): accepts the LSU's level-held request (adr/dat/bsel/we/req), performs a big-endian, byte-selectable access to an internal single-port word memory after a configurable number of wait states, and returns a single-cycle ack or err. It sits directly on the LSU's dbus in tightly-coupled-memory configurations and serves as the reference bus model for LSU verification.

---
 rtl/mor1kx_dbus_sram_responder.sv | 162 ++++++++++++++++
 tb/tb_mor1kx_dbus_sram_responder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mor1kx_dbus_sram_responder.sv
// Responder for the mor1kx CPU data bus: a big-endian, byte-selectable single-port word memory
// that answers each accepted request with a one-cycle ack or err after WAIT_STATES extra cycles.
module mor1kx_dbus_sram_responder #(
    parameter int unsigned OPTION_OPERAND_WIDTH = 32,
    parameter int unsigned MEM_ADDR_WIDTH       = 10,
    parameter logic [31:0] BASE_ADDR            = 32'h0000_0000,
    parameter int unsigned WAIT_STATES          = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [OPTION_OPERAND_WIDTH-1:0] dbus_adr_i,
    input  logic                            dbus_req_i,
    input  logic                            dbus_we_i,
    input  logic [3:0]                      dbus_bsel_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] dbus_dat_i,
    output logic                            dbus_ack_o,
    output logic                            dbus_err_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] dbus_dat_o
);

    localparam int unsigned DW    = OPTION_OPERAND_WIDTH;
    localparam int unsigned DEPTH = 1 << MEM_ADDR_WIDTH;
    localparam int unsigned HI_LSB = MEM_ADDR_WIDTH + 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [DW-1:0] adr_q, adr_d;
    logic [DW-1:0] dat_q, dat_d;
    logic [3:0]    bsel_q, bsel_d;
    logic          we_q, we_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic [DW-1:0] rdat_q, rdat_d;

    logic [DW-1:0] mem [DEPTH];

    logic [DW-1:0]             acc_adr;
    logic [DW-1:0]             acc_dat;
    logic [3:0]                acc_bsel;
    logic                      acc_we;
    logic [MEM_ADDR_WIDTH-1:0] acc_idx;
    logic                      acc_err;
    logic                      go_resp;
    logic                      mem_we;

    // The access happens on the edge entering RESP; with zero wait states that is the same
    // edge that captures the request, so decode from the live inputs while still in IDLE.
    always_comb begin
        acc_adr  = adr_q;
        acc_dat  = dat_q;
        acc_bsel = bsel_q;
        acc_we   = we_q;
        if (state_q == ST_IDLE) begin
            acc_adr  = dbus_adr_i;
            acc_dat  = dbus_dat_i;
            acc_bsel = dbus_bsel_i;
            acc_we   = dbus_we_i;
        end
        acc_idx = acc_adr[HI_LSB-1:2];
        acc_err = (acc_adr[DW-1:HI_LSB] != BASE_ADDR[DW-1:HI_LSB]) || (acc_bsel == 4'b0000);
    end

    // Next-state and response logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        bsel_d  = bsel_q;
        we_d    = we_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdat_d  = rdat_q;
        go_resp = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (dbus_req_i) begin
                    adr_d  = dbus_adr_i;
                    dat_d  = dbus_dat_i;
                    bsel_d = dbus_bsel_i;
                    we_d   = dbus_we_i;
                    cnt_d  = 4'(WAIT_STATES);
                    if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_RESP;
                        go_resp = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (!dbus_req_i) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = ST_RESP;
                        go_resp = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (go_resp) begin
            ack_d = !acc_err;
            err_d = acc_err;
            if (!acc_err && !acc_we) begin
                rdat_d = mem[acc_idx];
            end
        end
        mem_we = go_resp && !acc_err && acc_we;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            adr_q   <= '0;
            dat_q   <= '0;
            bsel_q  <= 4'd0;
            we_q    <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            bsel_q  <= bsel_d;
            we_q    <= we_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdat_q  <= rdat_d;
        end
    end

    // Memory is deliberately not reset; bsel[3] is the most significant byte lane.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_we && acc_bsel[i]) begin
                mem[acc_idx][i*8 +: 8] <= acc_dat[i*8 +: 8];
            end
        end
    end

    assign dbus_ack_o = ack_q;
    assign dbus_err_o = err_q;
    assign dbus_dat_o = rdat_q;

endmodule

// File: tb/tb_mor1kx_dbus_sram_responder.sv
// Directed bench: three responders (0, 2 and 3 wait states) sharing clock and reset.
module tb_mor1kx_dbus_sram_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] adr  [3];
    logic        req  [3];
    logic        we   [3];
    logic [3:0]  bsel [3];
    logic [31:0] wdat [3];
    logic        ack  [3];
    logic        err  [3];
    logic [31:0] dout [3];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mor1kx_dbus_sram_responder #(.WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst), .dbus_adr_i(adr[0]), .dbus_req_i(req[0]), .dbus_we_i(we[0]),
        .dbus_bsel_i(bsel[0]), .dbus_dat_i(wdat[0]), .dbus_ack_o(ack[0]), .dbus_err_o(err[0]),
        .dbus_dat_o(dout[0]));
    mor1kx_dbus_sram_responder #(.WAIT_STATES(2)) u_ws2 (
        .clk(clk), .rst(rst), .dbus_adr_i(adr[1]), .dbus_req_i(req[1]), .dbus_we_i(we[1]),
        .dbus_bsel_i(bsel[1]), .dbus_dat_i(wdat[1]), .dbus_ack_o(ack[1]), .dbus_err_o(err[1]),
        .dbus_dat_o(dout[1]));
    mor1kx_dbus_sram_responder #(.WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst(rst), .dbus_adr_i(adr[2]), .dbus_req_i(req[2]), .dbus_we_i(we[2]),
        .dbus_bsel_i(bsel[2]), .dbus_dat_i(wdat[2]), .dbus_ack_o(ack[2]), .dbus_err_o(err[2]),
        .dbus_dat_o(dout[2]));

    // One bus access from just after a clock edge; lat = edges until ack/err (99 on timeout).
    // Request fields are scrambled after the first edge to show they are only sampled in IDLE.
    task automatic access(input int k, input logic w, input logic [31:0] a, input logic [3:0] b,
                          input logic [31:0] d, output int lat, output logic got_ack,
                          output logic got_err, output logic [31:0] rd, output logic stable,
                          output logic after);
        logic [31:0] d0;
        logic done;
        d0 = dout[k];
        stable = 1'b1; lat = 99; got_ack = 1'b0; got_err = 1'b0; rd = dout[k]; done = 1'b0;
        req[k] = 1'b1; we[k] = w; adr[k] = a; bsel[k] = b; wdat[k] = d;
        for (int n = 1; n <= 40; n++) begin
            if (!done) begin
                @(posedge clk); #1;
                if (ack[k] || err[k]) begin
                    lat = n; got_ack = ack[k]; got_err = err[k]; rd = dout[k]; done = 1'b1;
                end else begin
                    if (dout[k] !== d0) stable = 1'b0;
                    adr[k] = ~a; wdat[k] = ~d; bsel[k] = ~b; we[k] = ~w;
                end
            end
        end
        req[k] = 1'b0;
        @(posedge clk); #1;
        after = ack[k] | err[k];
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (ack[k] !== 1'b0 || err[k] !== 1'b0 || dout[k] !== 32'h0) begin
                n_bad++;
                $display("FAIL reset[%0d]: ack=%b err=%b dat=%h, want 0 0 00000000", k, ack[k], err[k], dout[k]);
            end
        end
    endtask

    task automatic test_load_ws0();
        int lat; logic a, e, st, af; logic [31:0] rd;
        access(0, 1'b1, 32'h10, 4'hF, 32'h1122_3344, lat, a, e, rd, st, af);
        n_vec++;
        if (lat !== 1 || a !== 1'b1 || e !== 1'b0) begin
            n_bad++; $display("FAIL preload_ws0: lat=%0d ack=%b err=%b, want 1 1 0", lat, a, e);
        end
        access(0, 1'b0, 32'h10, 4'hF, 32'h0, lat, a, e, rd, st, af);
        n_vec++;
        if (lat !== 1 || a !== 1'b1 || e !== 1'b0 || af !== 1'b0) begin
            n_bad++; $display("FAIL load_ws0: lat=%0d ack=%b err=%b after=%b, want 1 1 0 0", lat, a, e, af);
        end
        n_vec++;
        if (rd !== 32'h1122_3344) begin
            n_bad++; $display("FAIL load_ws0_data: got %h want 11223344", rd);
        end
    endtask

    task automatic test_byte_store();
        int lat; logic a, e, st, af; logic [31:0] rd;
        access(0, 1'b1, 32'h20, 4'hF, 32'hAABB_CCDD, lat, a, e, rd, st, af);
        access(0, 1'b1, 32'h21, 4'b0100, 32'h5555_5555, lat, a, e, rd, st, af);
        n_vec++;
        if (a !== 1'b1 || e !== 1'b0 || rd !== 32'h1122_3344) begin
            n_bad++; $display("FAIL byte_store: ack=%b err=%b dat=%h, want 1 0 11223344", a, e, rd);
        end
        access(0, 1'b0, 32'h20, 4'hF, 32'h0, lat, a, e, rd, st, af);
        n_vec++;
        if (rd !== 32'hAA55_CCDD || a !== 1'b1) begin
            n_bad++; $display("FAIL byte_store_readback: got %h ack=%b want aa55ccdd 1", rd, a);
        end
    endtask

    task automatic test_errors();
        int lat; logic a, e, st, af; logic [31:0] rd;
        access(0, 1'b0, 32'h0000_1000, 4'hF, 32'h0, lat, a, e, rd, st, af);
        n_vec++;
        if (lat !== 1 || a !== 1'b0 || e !== 1'b1 || af !== 1'b0 || rd !== 32'hAA55_CCDD) begin
            n_bad++;
            $display("FAIL err_range: lat=%0d ack=%b err=%b after=%b dat=%h, want 1 0 1 0 aa55ccdd", lat, a, e, af, rd);
        end
        access(0, 1'b0, 32'h0, 4'b0000, 32'h0, lat, a, e, rd, st, af);
        n_vec++;
        if (lat !== 1 || a !== 1'b0 || e !== 1'b1 || rd !== 32'hAA55_CCDD) begin
            n_bad++; $display("FAIL err_bsel0: lat=%0d ack=%b err=%b dat=%h, want 1 0 1 aa55ccdd", lat, a, e, rd);
        end
        access(0, 1'b1, 32'h0000_1FFC, 4'hF, 32'hDEAD_BEEF, lat, a, e, rd, st, af);
        n_vec++;
        if (a !== 1'b0 || e !== 1'b1) begin
            n_bad++; $display("FAIL err_store_range: ack=%b err=%b, want 0 1", a, e);
        end
        access(0, 1'b0, 32'h0000_0FFC, 4'hF, 32'h0, lat, a, e, rd, st, af);
        n_vec++;
        if (a !== 1'b1 || e !== 1'b0) begin
            n_bad++; $display("FAIL top_word_inrange: ack=%b err=%b, want 1 0", a, e);
        end
    endtask

    task automatic test_back_to_back();
        int acks; logic prev; logic dbl;
        acks = 0; prev = 1'b0; dbl = 1'b0;
        req[0] = 1'b1; we[0] = 1'b0; adr[0] = 32'h10; bsel[0] = 4'hF;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk); #1;
            if (ack[0]) acks++;
            if (ack[0] && prev) dbl = 1'b1;
            prev = ack[0];
        end
        req[0] = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (acks !== 3 || dbl !== 1'b0 || dout[0] !== 32'h1122_3344) begin
            n_bad++; $display("FAIL back_to_back: acks=%0d consecutive=%b dat=%h, want 3 0 11223344", acks, dbl, dout[0]);
        end
    endtask

    task automatic test_wait3();
        int lat; logic a, e, st, af; logic [31:0] rd;
        access(2, 1'b1, 32'h10, 4'hF, 32'h1122_3344, lat, a, e, rd, st, af);
        n_vec++;
        if (lat !== 4 || a !== 1'b1) begin
            n_bad++; $display("FAIL ws3_store: lat=%0d ack=%b, want 4 1", lat, a);
        end
        access(2, 1'b0, 32'h10, 4'hF, 32'h0, lat, a, e, rd, st, af);
        access(2, 1'b1, 32'h14, 4'hF, 32'hCAFE_F00D, lat, a, e, rd, st, af);
        access(2, 1'b0, 32'h14, 4'hF, 32'h0, lat, a, e, rd, st, af);
        n_vec++;
        if (lat !== 4 || a !== 1'b1 || e !== 1'b0 || st !== 1'b1 || af !== 1'b0) begin
            n_bad++; $display("FAIL ws3_load: lat=%0d ack=%b err=%b stable=%b after=%b, want 4 1 0 1 0", lat, a, e, st, af);
        end
        n_vec++;
        if (rd !== 32'hCAFE_F00D) begin
            n_bad++; $display("FAIL ws3_load_data: got %h want cafef00d", rd);
        end
    endtask

    task automatic test_abort();
        int lat; logic a, e, st, af; logic [31:0] rd; logic seen;
        access(1, 1'b1, 32'h30, 4'hF, 32'h1234_5678, lat, a, e, rd, st, af);
        access(1, 1'b1, 32'h40, 4'hF, 32'h9ABC_DEF0, lat, a, e, rd, st, af);
        req[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h30; bsel[1] = 4'hF; wdat[1] = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        seen = ack[1] | err[1];
        req[1] = 1'b0;
        @(posedge clk); #1;
        seen = seen | ack[1] | err[1];
        access(1, 1'b0, 32'h40, 4'hF, 32'h0, lat, a, e, rd, st, af);
        n_vec++;
        if (seen !== 1'b0) begin
            n_bad++; $display("FAIL abort_no_resp: saw ack/err=%b want 0", seen);
        end
        n_vec++;
        if (lat !== 3 || a !== 1'b1 || rd !== 32'h9ABC_DEF0) begin
            n_bad++; $display("FAIL after_abort_load: lat=%0d ack=%b dat=%h, want 3 1 9abcdef0", lat, a, rd);
        end
        access(1, 1'b0, 32'h30, 4'hF, 32'h0, lat, a, e, rd, st, af);
        n_vec++;
        if (rd !== 32'h1234_5678) begin
            n_bad++; $display("FAIL abort_mem_unchanged: got %h want 12345678", rd);
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic a, e, st, af; logic [31:0] rd;
        access(1, 1'b1, 32'h50, 4'hF, 32'h0102_0304, lat, a, e, rd, st, af);
        access(1, 1'b0, 32'h50, 4'hF, 32'h0, lat, a, e, rd, st, af);
        req[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h50; bsel[1] = 4'hF; wdat[1] = 32'h0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_vec++;
        if (ack[1] !== 1'b0 || err[1] !== 1'b0 || dout[1] !== 32'h0) begin
            n_bad++; $display("FAIL reset_mid: ack=%b err=%b dat=%h, want 0 0 00000000", ack[1], err[1], dout[1]);
        end
        req[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        access(1, 1'b0, 32'h50, 4'hF, 32'h0, lat, a, e, rd, st, af);
        n_vec++;
        if (lat !== 3 || a !== 1'b1 || rd !== 32'h0102_0304) begin
            n_bad++; $display("FAIL post_reset_load: lat=%0d ack=%b dat=%h, want 3 1 01020304", lat, a, rd);
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            req[k] = 1'b0; we[k] = 1'b0; adr[k] = '0; bsel[k] = '0; wdat[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_load_ws0();
        test_byte_store();
        test_errors();
        test_back_to_back();
        test_wait3();
        test_abort();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
